jar_digit_streamer: RTL and testbench

// - Parametrised digit streamer: holds an index into an external synchronous digit ROM and steps through it.
//   - Stepping is by strobe, or free-run at a programmable rate.
//   - Direction is forward or backward.
//   - The index wraps modulo DEPTH (DEPTH need not be a power of two).
// - The index is loaded serially in LOAD_W-bit chunks, so it fits narrow tile pin budgets.
// - Presents the fetched digit plus a valid flag to a downstream 7-seg decoder.

---
 rtl/jar_digit_streamer.sv | 114 +++++++++++
 tb/tb_jar_digit_streamer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jar_digit_streamer.sv
// jar_digit_streamer: steps an index through an external synchronous digit ROM.
// The index advances by strobe or at a programmable free-run rate, in either
// direction, wrapping modulo DEPTH. It is loaded serially in LOAD_W-bit chunks.
// The fetched digit comes out two cycles after the index, with a valid flag.
module jar_digit_streamer #(
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 512,
  parameter int DIGIT_W    = 4,
  parameter int LOAD_W     = 5,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [LOAD_W-1:0]     load_data,
  input  logic                  step,
  input  logic                  run,
  input  logic                  dir,
  input  logic [PRESCALE_W-1:0] rate,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DIGIT_W-1:0]    rom_data,
  output logic [DIGIT_W-1:0]    digit,
  output logic                  digit_valid,
  output logic [ADDR_W-1:0]     index,
  output logic                  wrap
);

  // Last legal table entry, and DEPTH held one bit wider so that
  // DEPTH == 2**ADDR_W does not truncate to zero.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  logic [PRESCALE_W-1:0] presc;
  logic                  s0;

  logic                  tick;
  logic                  adv;
  logic [ADDR_W-1:0]     loaded_idx;
  logic [ADDR_W-1:0]     next_index;
  logic [PRESCALE_W-1:0] next_presc;
  logic                  next_wrap;

  // The index is the ROM address directly, so there is no input-to-address comb path.
  assign rom_addr = index;

  // The new chunk enters at the top and the oldest bits fall off the bottom.
  // A right shift of the concatenation also covers LOAD_W == ADDR_W.
  assign loaded_idx = ADDR_W'({load_data, index} >> LOAD_W);

  // Work out the advance event, the next index, the wrap flag and the prescaler.
  always_comb begin
    tick       = 1'b0;
    adv        = 1'b0;
    next_index = index;
    next_presc = presc;
    next_wrap  = 1'b0;

    tick = run && (presc == rate);
    adv  = !load && (step || tick);

    if (load) begin
      next_index = loaded_idx;
      next_presc = '0;
    end else begin
      if (run) begin
        next_presc = (presc == rate) ? '0 : presc + PRESCALE_W'(1);
      end else begin
        next_presc = '0;
      end

      if (adv) begin
        if (!dir) begin
          // Out-of-range loaded values also fold back to zero here.
          if (index >= LAST_IDX) begin
            next_index = '0;
            next_wrap  = 1'b1;
          end else begin
            next_index = index + ADDR_W'(1);
          end
        end else begin
          if (index == '0) begin
            next_index = LAST_IDX;
            next_wrap  = 1'b1;
          end else if ({1'b0, index} >= DEPTH_X) begin
            // Recovering from an out-of-range load is not a table wrap.
            next_index = LAST_IDX;
          end else begin
            next_index = index - ADDR_W'(1);
          end
        end
      end
    end
  end

  // Register the index state and the two-stage fetch and valid pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      index       <= '0;
      presc       <= '0;
      wrap        <= 1'b0;
      s0          <= 1'b0;
      digit_valid <= 1'b0;
      digit       <= '0;
    end else begin
      index       <= next_index;
      presc       <= next_presc;
      wrap        <= next_wrap;
      s0          <= ~load;
      digit_valid <= s0;
      digit       <= rom_data;
    end
  end

endmodule

// File: tb/tb_jar_digit_streamer.sv
// Self-checking bench for jar_digit_streamer. A reference model runs beside
// the default build. A second build with DEPTH=10 covers non-power-of-two wrap.
module tb_jar_digit_streamer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [4:0] load_data = '0;
  logic       step = 1'b0;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] rate = '0;

  logic [8:0] rom_addr, index;
  logic [3:0] rom_data, digit;
  logic       digit_valid, wrap;

  logic [8:0] rom_addr_10, index_10;
  logic [3:0] rom_data_10, digit_10;
  logic       digit_valid_10, wrap_10;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected digit and valid values for later cycles.
  logic [3:0] dq[$];
  logic       vq[$];
  logic [8:0] m_idx;
  logic [7:0] m_presc;
  logic       m_wrap;
  logic       m_adv;
  logic [3:0] exp_d;
  logic       exp_v;

  always #5 clk = ~clk;

  jar_digit_streamer dut (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data),
    .step(step), .run(run), .dir(dir), .rate(rate),
    .rom_addr(rom_addr), .rom_data(rom_data), .digit(digit),
    .digit_valid(digit_valid), .index(index), .wrap(wrap)
  );

  jar_digit_streamer #(.DEPTH(10)) dut10 (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data),
    .step(step), .run(run), .dir(dir), .rate(rate),
    .rom_addr(rom_addr_10), .rom_data(rom_data_10), .digit(digit_10),
    .digit_valid(digit_valid_10), .index(index_10), .wrap(wrap_10)
  );

  function automatic logic [3:0] rom_fn(input logic [8:0] a);
    return a[3:0] ^ 4'h5;
  endfunction

  always @(posedge clk) begin
    rom_data    <= rom_fn(rom_addr);
    rom_data_10 <= rom_fn(rom_addr_10);
  end

  // Model the index and push expectations on each edge, then check the
  // DUT once its outputs have settled.
  always @(posedge clk) begin
    if (reset) begin
      m_idx   = '0;
      m_presc = '0;
      m_wrap  = 1'b0;
      dq.delete();
      vq.delete();
      dq.push_back(rom_fn(9'd0));
      dq.push_back(rom_fn(9'd0));
      vq.push_back(1'b0);
    end else begin
      m_adv  = !load && (step || (run && (m_presc == rate)));
      m_wrap = 1'b0;
      if (load) begin
        m_idx   = {load_data, m_idx[8:5]};
        m_presc = '0;
      end else begin
        if (!run) m_presc = '0;
        else if (m_presc == rate) m_presc = '0;
        else m_presc = m_presc + 8'd1;
        if (m_adv) begin
          if (!dir) begin
            if (m_idx == 9'd511) begin m_idx = '0; m_wrap = 1'b1; end
            else m_idx = m_idx + 9'd1;
          end else begin
            if (m_idx == 9'd0) begin m_idx = 9'd511; m_wrap = 1'b1; end
            else m_idx = m_idx - 9'd1;
          end
        end
      end
      dq.push_back(rom_fn(m_idx));
      vq.push_back(!load);
      exp_d = dq.pop_front();
      exp_v = vq.pop_front();
      #1;
      n_checks++;
      if (index !== m_idx) begin
        n_fail++;
        $display("FAIL sb_index: got %h expected %h at %0t", index, m_idx, $time);
      end
      n_checks++;
      if (wrap !== m_wrap) begin
        n_fail++;
        $display("FAIL sb_wrap: got %b expected %b at %0t", wrap, m_wrap, $time);
      end
      n_checks++;
      if (digit !== exp_d) begin
        n_fail++;
        $display("FAIL sb_digit: got %h expected %h at %0t", digit, exp_d, $time);
      end
      n_checks++;
      if (digit_valid !== exp_v) begin
        n_fail++;
        $display("FAIL sb_valid: got %b expected %b at %0t", digit_valid, exp_v, $time);
      end
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; step = 1'b1;
    repeat (3) tick_clk();
    n_checks++;
    if (index !== 9'd0 || digit !== 4'h0 || digit_valid !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: idx=%h digit=%h valid=%b wrap=%b expected 0/0/0/0",
               index, digit, digit_valid, wrap);
    end
    reset = 1'b0; run = 1'b0; step = 1'b0;
    tick_clk();
    n_checks++;
    if (digit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_edge1: got %b expected 0", digit_valid);
    end
    tick_clk();
    n_checks++;
    if (digit_valid !== 1'b1 || digit !== 4'h5) begin
      n_fail++;
      $display("FAIL reset_valid_edge2: valid=%b digit=%h expected 1/5", digit_valid, digit);
    end
  endtask

  task automatic test_serial_load();
    load = 1'b1; load_data = 5'b01010;
    tick_clk();
    load_data = 5'b11010;
    tick_clk();
    load = 1'b0;
    n_checks++;
    if (index !== 9'h1A5 || digit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_index: idx=%h valid=%b expected 1a5/0", index, digit_valid);
    end
    tick_clk();
    n_checks++;
    if (digit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_bubble2: got %b expected 0", digit_valid);
    end
    tick_clk();
    n_checks++;
    if (digit_valid !== 1'b1 || digit !== 4'h0) begin
      n_fail++;
      $display("FAIL load_digit: valid=%b digit=%h expected 1/0", digit_valid, digit);
    end
  endtask

  task automatic test_wrap();
    load = 1'b1; load_data = 5'b11111;
    repeat (2) tick_clk();
    load = 1'b0; dir = 1'b0; step = 1'b1;
    tick_clk();
    step = 1'b0;
    n_checks++;
    if (index !== 9'd0 || wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_fwd: idx=%h wrap=%b expected 000/1", index, wrap);
    end
    tick_clk();
    n_checks++;
    if (wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_fwd_pulse: got %b expected 0", wrap);
    end
    dir = 1'b1; step = 1'b1;
    tick_clk();
    step = 1'b0;
    n_checks++;
    if (index !== 9'd511 || wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_bwd: idx=%h wrap=%b expected 1ff/1", index, wrap);
    end
    tick_clk();
    n_checks++;
    if (wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_bwd_pulse: got %b expected 0", wrap);
    end
    dir = 1'b0;
  endtask

  task automatic test_prescaler();
    load = 1'b1; load_data = 5'b00000;
    repeat (2) tick_clk();
    load = 1'b0; run = 1'b1; rate = 8'd3; dir = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick_clk();
      if (e % 4 == 0) begin
        n_checks++;
        if (index !== 9'(e / 4)) begin
          n_fail++;
          $display("FAIL presc_edge%0d: idx=%h expected %h", e, index, 9'(e / 4));
        end
      end
    end
    repeat (3) tick_clk();
    step = 1'b1;
    tick_clk();
    step = 1'b0;
    n_checks++;
    if (index !== 9'd4) begin
      n_fail++;
      $display("FAIL presc_step_tick: idx=%h expected 004", index);
    end
    run = 1'b0;
    tick_clk();
  endtask

  task automatic test_load_midrun();
    run = 1'b1; rate = 8'd0; dir = 1'b0;
    repeat (3) tick_clk();
    n_checks++;
    if (index !== 9'd7) begin
      n_fail++;
      $display("FAIL midrun_stream: idx=%h expected 007", index);
    end
    load = 1'b1; load_data = 5'b00011;
    tick_clk();
    load = 1'b0;
    n_checks++;
    if (index !== 9'h030 || digit_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_load: idx=%h valid=%b expected 030/1", index, digit_valid);
    end
    tick_clk();
    n_checks++;
    if (index !== 9'h031 || digit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_bubble: idx=%h valid=%b expected 031/0", index, digit_valid);
    end
    tick_clk();
    n_checks++;
    if (digit_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_recover: got %b expected 1", digit_valid);
    end
    run = 1'b0;
    tick_clk();
  endtask

  task automatic test_depth10();
    dir = 1'b0; run = 1'b0;
    load = 1'b1; load_data = 5'b10010;
    tick_clk();
    load_data = 5'b00000;
    tick_clk();
    load = 1'b0;
    n_checks++;
    if (index_10 !== 9'd9) begin
      n_fail++;
      $display("FAIL d10_load9: idx=%0d expected 9", index_10);
    end
    step = 1'b1;
    tick_clk();
    step = 1'b0;
    n_checks++;
    if (index_10 !== 9'd0 || wrap_10 !== 1'b1) begin
      n_fail++;
      $display("FAIL d10_fwd_wrap: idx=%0d wrap=%b expected 0/1", index_10, wrap_10);
    end
    load = 1'b1; load_data = 5'b11000;
    tick_clk();
    load_data = 5'b10010;
    tick_clk();
    load = 1'b0;
    n_checks++;
    if (index_10 !== 9'd300) begin
      n_fail++;
      $display("FAIL d10_load300: idx=%0d expected 300", index_10);
    end
    dir = 1'b1; step = 1'b1;
    tick_clk();
    step = 1'b0;
    n_checks++;
    if (index_10 !== 9'd9 || wrap_10 !== 1'b0) begin
      n_fail++;
      $display("FAIL d10_bwd_oor: idx=%0d wrap=%b expected 9/0", index_10, wrap_10);
    end
    dir = 1'b0;
    tick_clk();
  endtask

  initial begin
    test_reset();
    test_serial_load();
    test_wrap();
    test_prescaler();
    test_load_midrun();
    test_depth10();
    repeat (2) tick_clk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
